// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the branch resolution unit: funct3 branch types, comparator
// flag selection and FSM states.
package branch_resolve_pkg;

  // funct3 encodings of the conditional branches
  localparam logic [2:0] BrBeq  = 3'b000;
  localparam logic [2:0] BrBne  = 3'b001;
  localparam logic [2:0] BrBlt  = 3'b100;
  localparam logic [2:0] BrBge  = 3'b101;
  localparam logic [2:0] BrBltu = 3'b110;
  localparam logic [2:0] BrBgeu = 3'b111;

  // funct3 bit that selects an unsigned compare
  localparam int unsigned BrunUnsignedBit = 1;

  typedef enum logic [0:0] {
    BrIdle,
    BrSquash
  } br_state_e;

  // Taken decision of a conditional branch from the comparator flags.
  function automatic logic cond_taken(input logic [2:0] br_type, input logic br_eq,
                                      input logic br_lt);
    logic taken;
    case (br_type)
      BrBeq:          taken = br_eq;
      BrBne:          taken = !br_eq;
      BrBlt, BrBltu:  taken = br_lt;
      BrBge, BrBgeu:  taken = !br_lt;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolve_target.sv
// Combinational target adder and 4-byte alignment check, shared by the conditional
// branch, JAL and JALR paths.
module branch_resolve_target #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            is_jalr_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  // JALR adds to rs1 and clears bit 0; everything else is PC-relative
  always_comb begin
    target_o = (is_jalr_i ? rs1_i : pc_i) + imm_i;
    if (is_jalr_i) begin
      target_o[0] = 1'b0;
    end
    misaligned_o = |target_o[1:0];
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: taken decision, registered PC redirect and the
// wrong-path squash sequence. Optional perf counters enabled by BRANCH_PERF_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter int unsigned XLEN          = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            Valid_i,
  input  logic            Stall_i,
  input  logic [2:0]      BrType_i,
  input  logic            IsJal_i,
  input  logic            IsJalr_i,
  input  logic [XLEN-1:0] Pc_i,
  input  logic [XLEN-1:0] Imm_i,
  input  logic [XLEN-1:0] Rs1_i,
  input  logic            BrEq_i,
  input  logic            BrLt_i,
  output logic            BrUn_o,
  output logic            Redirect_o,
  output logic [XLEN-1:0] RedirectPc_o,
  output logic            Flush_o,
  output logic            MisalignExc_o,
  output logic [XLEN-1:0] BadPc_o
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     BrCount_o,
  output logic [31:0]     BrTakenCount_o
`endif
);

  localparam logic [1:0] CntLoad = 2'(SQUASH_CYCLES - 1);

  br_state_e       state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] bad_pc_q, bad_pc_d;

  logic            is_jump;
  logic            br_taken;
  logic            taken;
  logic            eval;
  logic            redirect_hit;
  logic [XLEN-1:0] target;
  logic            misaligned;

  branch_resolve_target #(
    .XLEN(XLEN)
  ) u_target (
    .pc_i        (Pc_i),
    .rs1_i       (Rs1_i),
    .imm_i       (Imm_i),
    .is_jalr_i   (IsJalr_i),
    .target_o    (target),
    .misaligned_o(misaligned)
  );

  // Comparator mode follows funct3 directly so it resolves in the same cycle
  assign BrUn_o = BrType_i[BrunUnsignedBit];

  // Taken decision; a wrong-path Valid_i during squash never evaluates
  always_comb begin
    is_jump      = IsJal_i | IsJalr_i;
    br_taken     = cond_taken(BrType_i, BrEq_i, BrLt_i);
    taken        = is_jump | br_taken;
    eval         = Valid_i && !Stall_i && (state_q == BrIdle);
    redirect_hit = eval && taken && !misaligned;
  end

  // Next-state for the squash FSM and the registered redirect/exception outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = redirect_hit;
    redirect_pc_d = redirect_hit ? target : redirect_pc_q;
    misalign_d    = eval && taken && misaligned;
    bad_pc_d      = (eval && taken && misaligned) ? target : bad_pc_q;
    unique case (state_q)
      BrIdle: begin
        if (redirect_hit) begin
          state_d = BrSquash;
          cnt_d   = CntLoad;
        end
      end
      BrSquash: begin
        if (cnt_q == 2'd0) begin
          state_d = BrIdle;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = BrIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= BrIdle;
      cnt_q         <= 2'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
      bad_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
      bad_pc_q      <= bad_pc_d;
    end
  end

  assign Redirect_o    = redirect_q;
  assign RedirectPc_o  = redirect_pc_q;
  assign MisalignExc_o = misalign_q;
  assign BadPc_o       = bad_pc_q;
  assign Flush_o       = (state_q == BrSquash);

`ifdef BRANCH_PERF_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] br_taken_count_q, br_taken_count_d;

  // Conditional-branch event counts; jumps are excluded, counters wrap
  always_comb begin
    br_count_d       = br_count_q;
    br_taken_count_d = br_taken_count_q;
    if (eval && !is_jump) begin
      br_count_d = br_count_q + 32'd1;
      if (br_taken) begin
        br_taken_count_d = br_taken_count_q + 32'd1;
      end
    end
  end

  // Perf counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      br_count_q       <= '0;
      br_taken_count_q <= '0;
    end else begin
      br_count_q       <= br_count_d;
      br_taken_count_q <= br_taken_count_d;
    end
  end

  assign BrCount_o      = br_count_q;
  assign BrTakenCount_o = br_taken_count_q;
`endif

endmodule
